// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: stage names, event kinds, priority pick.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  localparam int PIPE_DEFAULT_STAGES = 5;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } pipe_stage_t;

  // One pipeline event is acted on per cycle.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_STALL  = 2'd1,
    EV_REDIR  = 2'd2,
    EV_BUBBLE = 2'd3
  } pipe_event_t;

  // Memory wait beats redirect, which beats load-use.
  function automatic pipe_event_t pick_event(input logic stall, input logic redir,
                                             input logic load_use);
    if (stall) return EV_STALL;
    if (redir) return EV_REDIR;
    if (load_use) return EV_BUBBLE;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear and increment enable.
// Latency: count visible 1 cycle after the increment/clear.
// Backpressure: none; sticks at all-ones until cleared.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage valid bits, stage-register load/flush enables, event counters.
// Latency: enables combinational from inputs (0 cycles); valid bits and counters update next cycle.
// Backpressure: memory wait freezes all stage registers; load-use holds IF/ID and injects an EXE bubble.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = PIPE_DEFAULT_STAGES,
  parameter int REDIRECT_STAGE = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_read,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  redirect,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_is_load,
  input  logic                  clr_counters,
  output logic                  pc_load,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_count,
  output logic [CNT_WIDTH-1:0]  bubble_count
);

  localparam int R   = REDIRECT_STAGE;
  localparam int ID  = int'(ST_ID);
  localparam int EXE = int'(ST_EXE);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] load_en, flush_en;
  logic                  mem_stall, redir, load_use;
  pipe_event_t           evt;

  // Raw event detection; invalid stages cannot raise any of these.
  always_comb begin
    mem_stall = (imem_read & ~imem_resp) | (dmem_req & valid_q[R] & ~dmem_resp);
    redir     = redirect & valid_q[R];
    load_use  = valid_q[ID] & valid_q[EXE] & exe_is_load & (exe_rd != '0)
              & ((id_uses_rs1 & (id_rs1 == exe_rd)) | (id_uses_rs2 & (id_rs2 == exe_rd)));
    evt       = pick_event(mem_stall, redir, load_use);
  end

  // Enables and next valid bits for the winning event. IF always holds a
  // fetchable PC once out of reset, so valid[0] is simply forced to 1.
  always_comb begin
    load_en    = '1;
    flush_en   = '0;
    valid_d[0] = 1'b1;
    for (int k = 1; k < NUM_STAGES; k++) valid_d[k] = valid_q[k-1];
    unique case (evt)
      EV_STALL: begin
        load_en                  = '0;
        valid_d[NUM_STAGES-1:1]  = valid_q[NUM_STAGES-1:1];
      end
      EV_REDIR: begin
        // Younger instructions behind the redirect are squashed; the
        // redirecting instruction itself keeps moving toward WB.
        for (int k = 1; k <= R; k++) begin
          flush_en[k] = 1'b1;
          valid_d[k]  = 1'b0;
        end
      end
      EV_BUBBLE: begin
        load_en[0]    = 1'b0;
        load_en[ID]   = 1'b0;
        flush_en[EXE] = 1'b1;
        valid_d[ID]   = valid_q[ID];
        valid_d[EXE]  = 1'b0;
      end
      default: ;
    endcase
  end

  // Per-stage valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Enables are forced low while reset is held so stage registers stay put.
  assign stage_load  = load_en & {NUM_STAGES{~reset}};
  assign stage_flush = flush_en & {NUM_STAGES{~reset}};
  assign pc_load     = stage_load[0];
  assign stage_valid = valid_q;

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (clr_counters),
    .inc_i (evt == EV_STALL),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (clr_counters),
    .inc_i (evt == EV_REDIR),
    .cnt_o (flush_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (clr_counters),
    .inc_i (evt == EV_BUBBLE),
    .cnt_o (bubble_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, hand sequences, random run against an occupancy model.
// Latency: enables checked mid-cycle, state checked one cycle after the causing edge.
// Backpressure: stalls, redirects and bubbles all driven from the stimulus.
module tb_pipeline_ctrl;

  localparam int NS = 5;
  localparam int R  = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_read, imem_resp, dmem_req, dmem_resp, redirect;
  logic [AW-1:0] id_rs1, id_rs2, exe_rd;
  logic          id_uses_rs1, id_uses_rs2, exe_is_load, clr_counters;

  logic          pc_load, pc_load4;
  logic [NS-1:0] stage_load, stage_flush, stage_valid;
  logic [NS-1:0] stage_load4, stage_flush4, stage_valid4;
  logic [31:0]   stall_cycles, flush_count, bubble_count;
  logic [3:0]    stall4, flush4, bubble4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NUM_STAGES(NS), .REDIRECT_STAGE(R), .REG_ADDR_W(AW), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .redirect(redirect),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load), .clr_counters(clr_counters),
    .pc_load(pc_load), .stage_load(stage_load), .stage_flush(stage_flush),
    .stage_valid(stage_valid), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .bubble_count(bubble_count)
  );

  pipeline_ctrl #(.NUM_STAGES(NS), .REDIRECT_STAGE(R), .REG_ADDR_W(AW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .redirect(redirect),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load), .clr_counters(clr_counters),
    .pc_load(pc_load4), .stage_load(stage_load4), .stage_flush(stage_flush4),
    .stage_valid(stage_valid4), .stall_cycles(stall4), .flush_count(flush4),
    .bubble_count(bubble4)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // occ[k]: stage k holds a live instruction. Counters count events since the
  // last clear; a W-bit saturating counter then reads min(count, 2^W-1).
  bit     occ[NS];
  longint m_stall, m_flush, m_bub;

  // 0 none, 1 memory wait, 2 redirect, 3 load-use
  function automatic int model_event();
    bit s, r, lu;
    s  = (imem_read && !imem_resp) || (dmem_req && occ[R] && !dmem_resp);
    r  = redirect && occ[R];
    lu = occ[1] && occ[2] && exe_is_load && (exe_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == exe_rd) || (id_uses_rs2 && id_rs2 == exe_rd));
    if (s) return 1;
    if (r) return 2;
    if (lu) return 3;
    return 0;
  endfunction

  // {load[NS-1:0], flush[NS-1:0]}
  function automatic logic [2*NS-1:0] model_enables();
    logic [NS-1:0] ld, fl;
    int ev;
    ev = model_event();
    ld = '1;
    fl = '0;
    if (reset) ld = '0;
    else if (ev == 1) ld = '0;
    else if (ev == 2) begin
      for (int k = 1; k <= R; k++) fl[k] = 1'b1;
    end else if (ev == 3) begin
      ld[0] = 1'b0;
      ld[1] = 1'b0;
      fl[2] = 1'b1;
    end
    return {ld, fl};
  endfunction

  function automatic logic [NS-1:0] occ_vec();
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = occ[k];
    return v;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint cap;
    cap = (longint'(1) << w) - 1;
    return (v > cap) ? cap : v;
  endfunction

  // Model state advance: each stage takes its predecessor's instruction unless
  // the cycle's event pins or kills it.
  always @(posedge clk or posedge reset) begin
    int ev;
    bit nxt[NS];
    if (reset) begin
      for (int k = 0; k < NS; k++) occ[k] = 1'b0;
      m_stall = 0;
      m_flush = 0;
      m_bub   = 0;
    end else begin
      ev = model_event();
      for (int k = 0; k < NS; k++) begin
        if (k == 0)                  nxt[k] = 1'b1;
        else if (ev == 1)            nxt[k] = occ[k];
        else if (ev == 2 && k <= R)  nxt[k] = 1'b0;
        else if (ev == 3 && k == 1)  nxt[k] = occ[1];
        else if (ev == 3 && k == 2)  nxt[k] = 1'b0;
        else                         nxt[k] = occ[k-1];
      end
      occ = nxt;
      if (clr_counters) begin
        m_stall = 0;
        m_flush = 0;
        m_bub   = 0;
      end else if (ev == 1) m_stall++;
      else if (ev == 2) m_flush++;
      else if (ev == 3) m_bub++;
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [2*NS-1:0] e;
    if (chk_en) begin
      e = model_enables();
      check("m_pc_load", pc_load, e[NS]);
      check("m_stage_load", stage_load, e[2*NS-1:NS]);
      check("m_stage_flush", stage_flush, e[NS-1:0]);
      check("m_stage_valid", stage_valid, occ_vec());
      check("m_stall32", stall_cycles, sat(m_stall, 32));
      check("m_flush32", flush_count, sat(m_flush, 32));
      check("m_bubble32", bubble_count, sat(m_bub, 32));
      check("m_stall4", stall4, sat(m_stall, 4));
      check("m_flush4", flush4, sat(m_flush, 4));
      check("m_bubble4", bubble4, sat(m_bub, 4));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_read = 0; imem_resp = 1; dmem_req = 0; dmem_resp = 0; redirect = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    exe_rd = 0; exe_is_load = 0; clr_counters = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_pc_load", pc_load, 0);
    check("rst_stage_load", stage_load, 0);
    check("rst_stage_flush", stage_flush, 0);
    check("rst_stage_valid", stage_valid, 0);
    check("rst_counters", {stall_cycles, flush_count}, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic          ir, iresp, dreq, dresp, redir, is_load;
    logic [AW-1:0] rd, rs1, rs2;
    logic          u1, u2;
    logic [NS-1:0] e_load, e_flush, e_next;
    int            e_stall, e_flc, e_bub;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Vectors applied to a full pipeline (all five stages valid).
    tbl[0]  = '{0,1,0,0,0, 0, 0,0,0, 0,0, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[1]  = '{1,0,0,0,0, 0, 0,0,0, 0,0, 5'b00000, 5'b00000, 5'b11111, 1,0,0};
    tbl[2]  = '{1,1,0,0,0, 0, 0,0,0, 0,0, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[3]  = '{0,1,1,0,0, 0, 0,0,0, 0,0, 5'b00000, 5'b00000, 5'b11111, 1,0,0};
    tbl[4]  = '{0,1,1,1,0, 0, 0,0,0, 0,0, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[5]  = '{0,1,0,0,1, 0, 0,0,0, 0,0, 5'b11111, 5'b01110, 5'b10001, 0,1,0};
    tbl[6]  = '{0,1,0,0,0, 1, 5,0,5, 0,1, 5'b11100, 5'b00100, 5'b11011, 0,0,1};
    tbl[7]  = '{0,1,0,0,0, 1, 0,0,0, 0,1, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[8]  = '{0,1,0,0,0, 1, 7,7,0, 0,1, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[9]  = '{0,1,0,0,0, 1, 7,7,0, 1,0, 5'b11100, 5'b00100, 5'b11011, 0,0,1};
    tbl[10] = '{0,1,0,0,0, 0, 7,7,0, 1,0, 5'b11111, 5'b00000, 5'b11111, 0,0,0};
    tbl[11] = '{0,1,0,0,1, 1, 5,0,5, 0,1, 5'b11111, 5'b01110, 5'b10001, 0,1,0};
    tbl[12] = '{0,1,1,0,1, 0, 0,0,0, 0,0, 5'b00000, 5'b00000, 5'b11111, 1,0,0};

    idle_inputs();
    #2;
    do_reset();
    chk_en = 1'b1;

    // Fill from reset; an invalid MEM stage must ignore dmem_req and redirect.
    dmem_req = 1; dmem_resp = 0; redirect = 1;
    #1;
    check("inv_mem_load", stage_load, 5'b11111);
    check("inv_mem_flush", stage_flush, 5'b00000);
    tick();
    idle_inputs();
    check("fill_valid_1", stage_valid, 5'b00001);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("fill_valid", stage_valid, (64'd1 << i) - 1);
    end
    check("fill_counters", {stall_cycles, flush_count, bubble_count}, 0);

    // Three cycles of instruction-memory wait.
    imem_read = 1; imem_resp = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("istall_pc_load", pc_load, 0);
      check("istall_loads", stage_load, 0);
      tick();
    end
    idle_inputs();
    check("istall_valid", stage_valid, 5'b11111);
    check("istall_count", stall_cycles, 3);

    // Redirect from MEM.
    redirect = 1;
    #1;
    check("redir_flush", stage_flush, 5'b01110);
    check("redir_load", stage_load, 5'b11111);
    tick();
    idle_inputs();
    check("redir_valid", stage_valid, 5'b10001);
    check("redir_count", flush_count, 1);
    fill(4);

    // Load-use on rs2, then the x0 destination variant.
    exe_is_load = 1; exe_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    #1;
    check("lu_pc_load", pc_load, 0);
    check("lu_load", stage_load, 5'b11100);
    check("lu_flush", stage_flush, 5'b00100);
    tick();
    idle_inputs();
    check("lu_count", bubble_count, 1);
    check("lu_valid", stage_valid, 5'b11011);
    tick();
    exe_is_load = 1; exe_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    #1;
    check("lu_x0_load", stage_load, 5'b11111);
    tick();
    idle_inputs();
    check("lu_x0_count", bubble_count, 1);
    fill(3);
    check("pre_combo_valid", stage_valid, 5'b11111);

    // Redirect and load-use pending behind a two-cycle data-memory wait.
    dmem_req = 1; dmem_resp = 0; redirect = 1;
    exe_is_load = 1; exe_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("combo_hold_load", stage_load, 0);
      check("combo_hold_flush", stage_flush, 0);
      tick();
    end
    dmem_resp = 1;
    #1;
    check("combo_flush", stage_flush, 5'b01110);
    check("combo_load", stage_load, 5'b11111);
    tick();
    idle_inputs();
    check("combo_valid", stage_valid, 5'b10001);
    check("combo_flushes", flush_count, 2);
    check("combo_bubbles", bubble_count, 1);
    check("combo_stalls", stall_cycles, 5);

    // Saturation of the 4-bit counter and clear-beats-increment.
    do_reset();
    imem_read = 1; imem_resp = 0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall4", stall4, 4'hF);
    check("sat_stall32", stall_cycles, 20);
    clr_counters = 1;
    tick();
    check("clr_stall4", stall4, 0);
    check("clr_stall32", stall_cycles, 0);
    idle_inputs();

    // Reset asserted in the middle of a stall.
    fill(5);
    imem_read = 1; imem_resp = 0;
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", stage_valid, 0);
    check("midrst_loads", {pc_load, stage_load, stage_flush}, 0);
    check("midrst_stall", stall_cycles, 0);
    tick();
    reset = 1'b0;
    idle_inputs();

    // Vector table, each applied to a freshly filled pipeline.
    for (int v = 0; v < 13; v++) begin
      do_reset();
      fill(5);
      check("tbl_pre_valid", stage_valid, 5'b11111);
      imem_read = tbl[v].ir; imem_resp = tbl[v].iresp;
      dmem_req = tbl[v].dreq; dmem_resp = tbl[v].dresp; redirect = tbl[v].redir;
      exe_is_load = tbl[v].is_load; exe_rd = tbl[v].rd;
      id_rs1 = tbl[v].rs1; id_rs2 = tbl[v].rs2;
      id_uses_rs1 = tbl[v].u1; id_uses_rs2 = tbl[v].u2;
      #1;
      check($sformatf("tbl%0d_load", v), stage_load, tbl[v].e_load);
      check($sformatf("tbl%0d_flush", v), stage_flush, tbl[v].e_flush);
      tick();
      idle_inputs();
      check($sformatf("tbl%0d_valid", v), stage_valid, tbl[v].e_next);
      check($sformatf("tbl%0d_stall", v), stall_cycles, tbl[v].e_stall);
      check($sformatf("tbl%0d_flushes", v), flush_count, tbl[v].e_flc);
      check($sformatf("tbl%0d_bubbles", v), bubble_count, tbl[v].e_bub);
    end

    // Random traffic; the mid-cycle checker compares everything to the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      imem_read    = ($urandom_range(3) != 0);
      imem_resp    = ($urandom_range(3) != 0);
      dmem_req     = ($urandom_range(2) == 0);
      dmem_resp    = ($urandom_range(2) != 0);
      redirect     = ($urandom_range(6) == 0);
      exe_is_load  = ($urandom_range(1) == 0);
      exe_rd       = AW'($urandom_range(3));
      id_rs1       = AW'($urandom_range(3));
      id_rs2       = AW'($urandom_range(3));
      id_uses_rs1  = ($urandom_range(1) == 0);
      id_uses_rs2  = ($urandom_range(1) == 0);
      clr_counters = ($urandom_range(40) == 0);
      reset        = ($urandom_range(150) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
